// File: rtl/pid_calc.sv
// pid_calc: per-axis PID u = Kp*e + Ki*ie + Kd*de on one shared signed multiplier, saturated to OUT_W bits
// Define PID_OUT_LIMIT_EN to add a symmetric +/-OUT_LIMIT clamp after saturation.
module pid_calc #(
    parameter int               DW        = 24,
    parameter int               GW        = 16,
    parameter int               FRAC      = 8,
    parameter int               OUT_W     = 16,
    parameter logic [OUT_W-1:0] OUT_LIMIT = 16'd8000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pid_start,
    input  logic signed [DW-1:0]    pitch_error,
    input  logic signed [DW-1:0]    roll_error,
    input  logic signed [DW-1:0]    yaw_error,
    input  logic signed [DW-1:0]    i_pitch_error,
    input  logic signed [DW-1:0]    i_roll_error,
    input  logic signed [DW-1:0]    i_yaw_error,
    input  logic signed [DW-1:0]    d_pitch_error,
    input  logic signed [DW-1:0]    d_roll_error,
    input  logic signed [DW-1:0]    d_yaw_error,
    input  logic signed [GW-1:0]    kp,
    input  logic signed [GW-1:0]    ki,
    input  logic signed [GW-1:0]    kd,
    output logic signed [OUT_W-1:0] pitch_out,
    output logic signed [OUT_W-1:0] roll_out,
    output logic signed [OUT_W-1:0] yaw_out,
    output logic                    pid_busy,
    output logic                    pid_done
);
    localparam int PW = DW + GW;
    localparam int AW = PW + 2;
    localparam logic signed [AW-1:0] S_MAX = AW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [AW-1:0] S_MIN = ~S_MAX;
`ifdef PID_OUT_LIMIT_EN
    localparam logic signed [OUT_W-1:0] L_MAX = OUT_LIMIT;
    localparam logic signed [OUT_W-1:0] L_MIN = -L_MAX;
`endif
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_nx;
    logic signed [DW-1:0]    err_r [3][3];
    logic signed [GW-1:0]    gain_r [3];
    logic [1:0]              axis, term;
    logic signed [AW-1:0]    acc, sum, shifted;
    logic signed [PW-1:0]    prod;
    logic signed [OUT_W-1:0] sat, lim;
    logic signed [OUT_W-1:0] hold [3];

    assign pid_busy = state != IDLE;

    always_comb begin
        prod    = PW'(err_r[axis][term]) * PW'(gain_r[term]);
        sum     = acc + AW'(prod);
        shifted = sum >>> FRAC;
        sat     = shifted > S_MAX ? S_MAX[OUT_W-1:0] : shifted < S_MIN ? S_MIN[OUT_W-1:0] : shifted[OUT_W-1:0];
`ifdef PID_OUT_LIMIT_EN
        lim     = sat > L_MAX ? L_MAX : sat < L_MIN ? L_MIN : sat;
`else
        lim     = sat;
`endif
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && pid_start) state_nx = MAC;
        if (state == MAC && axis == 2'd2 && term == 2'd2) state_nx = OUT;
        if (state == OUT) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r     <= '{default: '0};
            gain_r    <= '{default: '0};
            hold      <= '{default: '0};
            acc       <= '0;
            axis      <= '0;
            term      <= '0;
            pitch_out <= '0;
            roll_out  <= '0;
            yaw_out   <= '0;
            pid_done  <= 1'b0;
        end else begin
            pid_done <= state == OUT;
            if (state == IDLE && pid_start) begin
                err_r  <= '{'{pitch_error, i_pitch_error, d_pitch_error},
                            '{roll_error, i_roll_error, d_roll_error},
                            '{yaw_error, i_yaw_error, d_yaw_error}};
                gain_r <= '{kp, ki, kd};
                acc    <= '0;
                axis   <= '0;
                term   <= '0;
            end
            if (state == MAC) begin
                acc  <= term == 2'd2 ? '0 : sum;
                term <= term == 2'd2 ? 2'd0 : term + 2'd1;
                if (term == 2'd2) begin
                    hold[axis] <= lim;
                    axis       <= axis + 2'd1;
                end
            end
            if (state == OUT) begin
                pitch_out <= hold[0];
                roll_out  <= hold[1];
                yaw_out   <= hold[2];
            end
        end
    end
endmodule

// File: tb/tb_pid_calc.sv
// tb_pid_calc: randomized and directed scoreboard bench for pid_calc
module tb_pid_calc;
    localparam int LIM = 1000;
    typedef struct {
        int p;
        int r;
        int y;
        int cyc;
    } exp_t;

    logic clk = 0, rst = 1, pid_start = 0;
    logic signed [23:0] e [3][3];
    logic signed [15:0] g [3];
    logic signed [15:0] pitch_out, roll_out, yaw_out;
    logic pid_busy, pid_done;
    exp_t q[$];
    exp_t cur = '{0, 0, 0, 0};
    exp_t mx;
    int n_chk = 0, n_fail = 0, cyc = 0;

    pid_calc #(.OUT_LIMIT(16'd1000)) dut (
        .clk(clk), .rst(rst), .pid_start(pid_start),
        .pitch_error(e[0][0]), .i_pitch_error(e[0][1]), .d_pitch_error(e[0][2]),
        .roll_error(e[1][0]), .i_roll_error(e[1][1]), .d_roll_error(e[1][2]),
        .yaw_error(e[2][0]), .i_yaw_error(e[2][1]), .d_yaw_error(e[2][2]),
        .kp(g[0]), .ki(g[1]), .kd(g[2]),
        .pitch_out(pitch_out), .roll_out(roll_out), .yaw_out(yaw_out),
        .pid_busy(pid_busy), .pid_done(pid_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int clampf(longint v);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`ifdef PID_OUT_LIMIT_EN
        if (v > LIM) v = LIM;
        if (v < -LIM) v = -LIM;
`endif
        return int'(v);
    endfunction

    function automatic exp_t model();
        exp_t x;
        int r [3];
        for (int a = 0; a < 3; a++) begin
            longint s = 0;
            for (int t = 0; t < 3; t++) s += longint'(e[a][t]) * longint'(g[t]);
            r[a] = clampf(s >>> 8);
        end
        x.p = r[0];
        x.r = r[1];
        x.y = r[2];
        x.cyc = cyc + 11;
        return x;
    endfunction

    task automatic set_zero();
        for (int a = 0; a < 3; a++) begin
            g[a] = '0;
            for (int t = 0; t < 3; t++) e[a][t] = '0;
        end
    endtask

    task automatic rand_in();
        bit wide = 1'($urandom_range(0, 1));
        for (int a = 0; a < 3; a++) begin
            g[a] = wide ? 16'($urandom) : 16'(int'($urandom_range(0, 1024)) - 512);
            for (int t = 0; t < 3; t++)
                e[a][t] = wide ? 24'($urandom) : 24'(int'($urandom_range(0, 8000)) - 4000);
        end
    endtask

    task automatic issue(input bit push);
        pid_start = 1;
        if (push) q.push_back(model());
        @(posedge clk) #1 pid_start = 0;
        if (push) chk("busy_after_start", pid_busy, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!pid_done && n < 20) begin
            @(posedge clk) #1;
            n++;
            rand_in();
        end
        chk("done_seen", pid_done, 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_pitch", pitch_out, 0);
            chk("rst_roll", roll_out, 0);
            chk("rst_yaw", yaw_out, 0);
            chk("rst_busy", pid_busy, 0);
            chk("rst_done", pid_done, 0);
        end else if (pid_done) begin
            chk("done_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                mx = q.pop_front();
                chk("pitch_out", pitch_out, mx.p);
                chk("roll_out", roll_out, mx.r);
                chk("yaw_out", yaw_out, mx.y);
                chk("latency", cyc, mx.cyc);
                chk("busy_at_done", pid_busy, 0);
                cur = mx;
            end
        end else begin
            chk("hold_pitch", pitch_out, cur.p);
            chk("hold_roll", roll_out, cur.r);
            chk("hold_yaw", yaw_out, cur.y);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        set_zero();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        set_zero(); g[0] = 16'sh0100; e[0][0] = 24'sd100;
        issue(1); wait_done();
        set_zero(); g[0] = 16'sh0100; g[1] = 16'sh0040; g[2] = 16'sh0080;
        e[1][0] = 24'sd400; e[1][1] = -24'sd800; e[1][2] = -24'sd200;
        issue(1); wait_done();
        set_zero(); g[0] = 16'sh7FFF; e[2][0] = 24'sh7FFFFF;
        issue(1); wait_done();
        set_zero(); g[0] = 16'sh7FFF; e[2][0] = -24'sh7FFFFF;
        issue(1); wait_done();
        set_zero(); g[0] = 16'sh0100; e[0][0] = 24'sd5000;
        issue(1); wait_done();
        set_zero(); g[0] = 16'sh0100; e[0][0] = -24'sd5000;
        issue(1); wait_done();
        rand_in(); issue(1);
        repeat (3) @(posedge clk) #1;
        rand_in(); issue(0);
        wait_done();
        rand_in(); issue(1); wait_done();
        rand_in(); issue(1);
        repeat (4) @(posedge clk) #1;
        rst = 1;
        q.delete();
        cur = '{0, 0, 0, 0};
        @(posedge clk) #1 rst = 0;
        chk("busy_after_rst", pid_busy, 0);
        repeat (15) @(posedge clk) #1;
        rand_in(); issue(1); wait_done();
        repeat (40) begin
            rand_in(); issue(1); wait_done();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(posedge clk) #1;
        end
        repeat (3) @(posedge clk) #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
